// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / PLL reset sequencer.
// Holds all PLLs in reset for a fixed time, waits for every synchronised lock
// to stay high long enough, then releases the domain resets one at a time in
// index order. A lock drop or a software request restarts the whole chain.
// Ports:
//   clk, rst_n    : board clock, asynchronous active-low reset
//   pll_lock      : raw PLL lock inputs (asynchronous, 3-flop synchronised)
//   sw_reset      : single-cycle request to re-sequence everything
//   pll_rst_n     : PLL resets (all bits identical)
//   domain_rst_n  : sequenced downstream resets, active-low
//   all_ready     : high only in RUN
//   lock_lost     : one-cycle pulse on a lock drop in RELEASE/RUN
//   timeout       : one-cycle pulse on a WAIT_LOCK timeout
//   retry_count   : saturating count of WAIT_LOCK timeouts
//   state         : 0 PLL_RESET, 1 WAIT_LOCK, 2 RELEASE, 3 RUN
module reset_sequencer #(
  parameter int unsigned NUM_PLLS              = 2,
  parameter int unsigned NUM_DOMAINS           = 4,
  parameter int unsigned PLL_RST_CYCLES        = 256,
  parameter int unsigned LOCK_STABLE_CYCLES    = 1024,
  parameter int unsigned DOMAIN_STAGGER_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES   = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PLLS-1:0]    pll_lock,
  input  logic                   sw_reset,
  output logic [NUM_PLLS-1:0]    pll_rst_n,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   all_ready,
  output logic                   lock_lost,
  output logic                   timeout,
  output logic [7:0]             retry_count,
  output logic [1:0]             state
);

  localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned STG_W = $clog2(DOMAIN_STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_PLLS-1:0]    pll_rst_n_d;
  logic [NUM_DOMAINS-1:0] domain_rst_n_d;
  logic                   all_ready_d, lock_lost_d, timeout_d;
  logic [7:0]             retry_count_d;
  logic [RST_W-1:0]       rst_cnt, rst_cnt_d;
  logic [STB_W-1:0]       stab_cnt, stab_cnt_d;
  logic [TO_W-1:0]        to_cnt, to_cnt_d;
  logic [STG_W-1:0]       stag_cnt, stag_cnt_d;
  logic [IDX_W-1:0]       dom_idx, dom_idx_d;

  logic [NUM_PLLS-1:0]    sync1, sync2, sync3;
  logic                   locked;

  assign state  = state_q;
  assign locked = &sync3;

  // Per-bit 3-flop lock synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= pll_lock;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // State, output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PLL_RESET;
      pll_rst_n    <= '0;
      domain_rst_n <= '0;
      all_ready    <= 1'b0;
      lock_lost    <= 1'b0;
      timeout      <= 1'b0;
      retry_count  <= 8'd0;
      rst_cnt      <= '0;
      stab_cnt     <= '0;
      to_cnt       <= '0;
      stag_cnt     <= '0;
      dom_idx      <= '0;
    end else begin
      state_q      <= state_d;
      pll_rst_n    <= pll_rst_n_d;
      domain_rst_n <= domain_rst_n_d;
      all_ready    <= all_ready_d;
      lock_lost    <= lock_lost_d;
      timeout      <= timeout_d;
      retry_count  <= retry_count_d;
      rst_cnt      <= rst_cnt_d;
      stab_cnt     <= stab_cnt_d;
      to_cnt       <= to_cnt_d;
      stag_cnt     <= stag_cnt_d;
      dom_idx      <= dom_idx_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    pll_rst_n_d    = pll_rst_n;
    domain_rst_n_d = domain_rst_n;
    all_ready_d    = all_ready;
    lock_lost_d    = 1'b0;
    timeout_d      = 1'b0;
    retry_count_d  = retry_count;
    rst_cnt_d      = rst_cnt;
    stab_cnt_d     = stab_cnt;
    to_cnt_d       = to_cnt;
    stag_cnt_d     = stag_cnt;
    dom_idx_d      = dom_idx;

    if (sw_reset) begin
      // Software request overrides everything, without pulses or retry count
      state_d        = S_PLL_RESET;
      pll_rst_n_d    = '0;
      domain_rst_n_d = '0;
      all_ready_d    = 1'b0;
      rst_cnt_d      = '0;
      stab_cnt_d     = '0;
      to_cnt_d       = '0;
      stag_cnt_d     = '0;
      dom_idx_d      = '0;
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
            state_d     = S_WAIT_LOCK;
            pll_rst_n_d = '1;
            rst_cnt_d   = '0;
            stab_cnt_d  = '0;
            to_cnt_d    = '0;
          end else begin
            rst_cnt_d = rst_cnt + RST_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Stability completion wins over a same-cycle timeout
          if (locked && stab_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_d    = S_RELEASE;
            stab_cnt_d = '0;
            to_cnt_d   = '0;
            stag_cnt_d = '0;
            dom_idx_d  = '0;
          end else if (to_cnt == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state_d     = S_PLL_RESET;
            pll_rst_n_d = '0;
            timeout_d   = 1'b1;
            if (retry_count != 8'hFF) retry_count_d = retry_count + 8'd1;
            rst_cnt_d   = '0;
            stab_cnt_d  = '0;
            to_cnt_d    = '0;
          end else begin
            stab_cnt_d = locked ? stab_cnt + STB_W'(1) : '0;
            to_cnt_d   = to_cnt + TO_W'(1);
          end
        end
        S_RELEASE: begin
          if (!locked) begin
            state_d        = S_PLL_RESET;
            pll_rst_n_d    = '0;
            domain_rst_n_d = '0;
            lock_lost_d    = 1'b1;
            rst_cnt_d      = '0;
          end else if (dom_idx == IDX_W'(NUM_DOMAINS)) begin
            state_d     = S_RUN;
            all_ready_d = 1'b1;
          end else if (stag_cnt == STG_W'(DOMAIN_STAGGER_CYCLES - 1)) begin
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              if (dom_idx == IDX_W'(i)) domain_rst_n_d[i] = 1'b1;
            end
            dom_idx_d  = dom_idx + IDX_W'(1);
            stag_cnt_d = '0;
          end else begin
            stag_cnt_d = stag_cnt + STG_W'(1);
          end
        end
        S_RUN: begin
          if (!locked) begin
            state_d        = S_PLL_RESET;
            pll_rst_n_d    = '0;
            domain_rst_n_d = '0;
            all_ready_d    = 1'b0;
            lock_lost_d    = 1'b1;
            rst_cnt_d      = '0;
          end
        end
        default: state_d = S_PLL_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus a randomized run,
// checked cycle by cycle against a phase/elapsed-time reference model.
module tb_reset_sequencer;

  localparam int NP  = 2;
  localparam int ND  = 3;
  localparam int PRC = 8;
  localparam int LSC = 4;
  localparam int DSC = 2;
  localparam int LTC = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sw_reset = 1'b0;
  logic [NP-1:0] pll_lock = '1;
  logic [NP-1:0] pll_rst_n;
  logic [ND-1:0] domain_rst_n;
  logic          all_ready, lock_lost, timeout;
  logic [7:0]    retry_count;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;

  reset_sequencer #(
    .NUM_PLLS(NP), .NUM_DOMAINS(ND), .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE_CYCLES(LSC), .DOMAIN_STAGGER_CYCLES(DSC),
    .LOCK_TIMEOUT_CYCLES(LTC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_reset(sw_reset),
    .pll_rst_n(pll_rst_n), .domain_rst_n(domain_rst_n), .all_ready(all_ready),
    .lock_lost(lock_lost), .timeout(timeout), .retry_count(retry_count),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {state, pll_rst_n, domain_rst_n, all_ready, lock_lost, timeout, retry_count};

  // Reference model: phase number plus cycles elapsed in the phase
  int          m_phase = 0, m_e = 0, m_stab = 0, m_retry = 0, m_r = 0;
  bit          m_lost = 0, m_to = 0, m_lk = 0;
  bit [2:0]    m_hist = '0;
  logic [ND-1:0] m_mask;
  logic [17:0] exp_vec = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_e = 0; m_stab = 0; m_retry = 0;
      m_lost = 0; m_to = 0; m_hist = '0;
    end else begin
      m_lk   = m_hist[2];
      m_hist = {m_hist[1:0], &pll_lock};
      m_lost = 0;
      m_to   = 0;
      if (sw_reset) begin
        m_phase = 0; m_e = 0; m_stab = 0;
      end else begin
        case (m_phase)
          0: begin
            m_e++;
            if (m_e == PRC) begin m_phase = 1; m_e = 0; m_stab = 0; end
          end
          1: begin
            m_e++;
            m_stab = m_lk ? m_stab + 1 : 0;
            if (m_stab == LSC) begin
              m_phase = 2; m_e = 0;
            end else if (m_e == LTC) begin
              m_phase = 0; m_e = 0; m_to = 1;
              if (m_retry < 255) m_retry++;
            end
          end
          2: begin
            if (!m_lk) begin m_phase = 0; m_e = 0; m_lost = 1; end
            else begin
              m_e++;
              if (m_e == ND * DSC + 1) m_phase = 3;
            end
          end
          default: begin
            if (!m_lk) begin m_phase = 0; m_e = 0; m_lost = 1; end
          end
        endcase
      end
    end
    if (m_phase == 3) m_mask = '1;
    else if (m_phase == 2) begin
      m_r = m_e / DSC;
      if (m_r > ND) m_r = ND;
      m_mask = ND'((1 << m_r) - 1);
    end else m_mask = '0;
    exp_vec = {2'(m_phase), (m_phase != 0) ? 2'b11 : 2'b00, m_mask,
               m_phase == 3, m_lost, m_to, 8'(m_retry)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    sw_reset = 1'b0;
    pll_lock = '1;
    repeat (3) tick();
    tests++; if (dut_vec !== 18'h0) begin fails++; $display("FAIL reset_values got %h exp %h", dut_vec, 18'h0); end
    tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_reset dut=%h model=%h", dut_vec, exp_vec); end
  endtask

  task automatic test_nominal();
    int n;
    int rise [ND];
    int rdy_at;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && pll_rst_n !== 2'b11; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_nominal t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (n != PRC) begin fails++; $display("FAIL nominal_pll_hold got %0d exp %0d", n, PRC); end
    for (int k = 0; k < ND; k++) rise[k] = -1;
    rdy_at = -1;
    for (int i = 1; i <= 40 && rdy_at < 0; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_nominal t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      for (int k = 0; k < ND; k++) if (rise[k] < 0 && domain_rst_n[k] === 1'b1) rise[k] = i;
      if (all_ready === 1'b1) rdy_at = i;
    end
    for (int k = 0; k < ND; k++) begin
      tests++; if (rise[k] != LSC + DSC + k * DSC) begin fails++; $display("FAIL nominal_domain%0d_rise got %0d exp %0d", k, rise[k], LSC + DSC + k * DSC); end
    end
    tests++; if (rdy_at != LSC + ND * DSC + 1) begin fails++; $display("FAIL nominal_all_ready got %0d exp %0d", rdy_at, LSC + ND * DSC + 1); end
  endtask

  task automatic test_timeout();
    int n;
    int cnt;
    pll_lock[1] = 1'b0;
    for (int i = 0; i < 200 && state !== 2'd1; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_timeout t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL timeout_reach_wait got %0d exp 1", state); end
    for (int rep = 1; rep <= 3; rep++) begin
      n = 0;
      for (int i = 0; i < 100 && timeout !== 1'b1; i++) begin
        tick(); n++;
        tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_timeout t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end
      tests++; if (n != LTC) begin fails++; $display("FAIL timeout_latency got %0d exp %0d", n, LTC); end
      tests++; if (retry_count !== 8'(rep)) begin fails++; $display("FAIL retry_step got %0d exp %0d", retry_count, rep); end
      tests++; if (state !== 2'd0 || pll_rst_n !== 2'b00) begin fails++; $display("FAIL timeout_to_pll_reset got state %0d pll %b exp 0 00", state, pll_rst_n); end
      n = 0;
      for (int i = 0; i < 100 && pll_rst_n !== 2'b11; i++) begin
        tick(); n++;
        tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_timeout t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      end
      tests++; if (n != PRC) begin fails++; $display("FAIL retry_pll_hold got %0d exp %0d", n, PRC); end
    end
    cnt = 0;
    for (int i = 0; i < 297 * (LTC + PRC) + 100 && cnt < 297; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_timeout t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      if (timeout === 1'b1) cnt++;
    end
    tests++; if (cnt != 297) begin fails++; $display("FAIL timeout_pulse_count got %0d exp 297", cnt); end
    tests++; if (retry_count !== 8'd255) begin fails++; $display("FAIL retry_saturate got %0d exp 255", retry_count); end
  endtask

  task automatic test_glitch();
    int n;
    bit to_seen;
    pll_lock = '1;
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    tests++; if (state !== 2'd0 || pll_rst_n !== 2'b00 || domain_rst_n !== 3'b000) begin fails++; $display("FAIL sw_reset_state got %h exp state0 all low", dut_vec); end
    tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_glitch t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    for (int i = 0; i < 50 && state !== 2'd1; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_glitch t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    pll_lock[0] = 1'b0;
    n = 0;
    to_seen = 0;
    tick(); n++;
    pll_lock[0] = 1'b1;
    for (int i = 0; i < 50 && state !== 2'd2; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_glitch t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
      if (timeout === 1'b1) to_seen = 1;
    end
    tests++; if (n != 3 + 1 + LSC) begin fails++; $display("FAIL glitch_release_time got %0d exp %0d", n, 3 + 1 + LSC); end
    tests++; if (to_seen) begin fails++; $display("FAIL glitch_timeout got 1 exp 0"); end
  endtask

  task automatic test_lock_loss_run();
    int n;
    for (int i = 0; i < 100 && state !== 2'd3; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_loss t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL loss_reach_run got %0d exp 3", state); end
    pll_lock[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && domain_rst_n !== 3'b000; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_loss t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (n != 4) begin fails++; $display("FAIL loss_latency got %0d exp 4", n); end
    tests++; if (lock_lost !== 1'b1 || state !== 2'd0 || all_ready !== 1'b0) begin fails++; $display("FAIL loss_pulse got lost %b state %0d ready %b exp 1 0 0", lock_lost, state, all_ready); end
    pll_lock[0] = 1'b1;
    tick();
    n = 1;
    tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL loss_pulse_width got %b exp 0", lock_lost); end
    for (int i = 0; i < 100 && pll_rst_n !== 2'b11; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_loss t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (n != PRC) begin fails++; $display("FAIL loss_pll_hold got %0d exp %0d", n, PRC); end
    n = 0;
    for (int i = 0; i < 40 && all_ready !== 1'b1; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_loss t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (n != LSC + ND * DSC + 1) begin fails++; $display("FAIL loss_resequence got %0d exp %0d", n, LSC + ND * DSC + 1); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] saved;
    saved = retry_count;
    pll_lock[0] = 1'b0;
    repeat (3) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_simul t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    tests++; if (state !== 2'd0 || pll_rst_n !== 2'b00 || domain_rst_n !== 3'b000) begin fails++; $display("FAIL simul_state got %h exp state0 all low", dut_vec); end
    tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL simul_lock_lost got %b exp 0", lock_lost); end
    tests++; if (retry_count !== saved) begin fails++; $display("FAIL simul_retry got %0d exp %0d", retry_count, saved); end
    tick();
    tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL simul_lock_lost_late got %b exp 0", lock_lost); end
    tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_simul t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    pll_lock[0] = 1'b1;
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 100 && domain_rst_n !== 3'b001; i++) begin
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_async t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL async_reach_release got %0d exp 2", state); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (dut_vec !== 18'h0) begin fails++; $display("FAIL async_reset_values got %h exp %h", dut_vec, 18'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && pll_rst_n !== 2'b11; i++) begin
      tick(); n++;
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_async t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    tests++; if (n != PRC) begin fails++; $display("FAIL async_pll_hold got %0d exp %0d", n, PRC); end
  endtask

  task automatic test_random();
    int hold_low;
    int sw_hold;
    hold_low = 0;
    sw_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_low > 0) begin
        hold_low--;
        if (hold_low == 0) pll_lock = '1;
      end else if ($urandom_range(0, 99) < 3) begin
        pll_lock = NP'($urandom_range(0, 2));
        hold_low = $urandom_range(1, 45);
      end
      if (sw_hold > 0) sw_hold--;
      else if ($urandom_range(0, 249) == 0) sw_hold = $urandom_range(1, 4);
      sw_reset = (sw_hold > 0);
      tick();
      tests++; if (dut_vec !== exp_vec) begin fails++; $display("FAIL model_random t=%0t dut=%h model=%h", $time, dut_vec, exp_vec); end
    end
    sw_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_lock_loss_run();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
